// File: rtl/video_pixout.sv
// Pixel output stage: line FIFO between the upstream fetcher and the timing generator.
// It requests lines, aligns the frame on s_sof and emits pixels one cycle after pixelena.
module video_pixout #(
    parameter int                 DATA_W   = 24,
    parameter int                 FIFO_AW  = 11,
    parameter int                 V_ACTIVE = 900,
    parameter logic [DATA_W-1:0]  BG_COLOR = 24'h000000
) (
    input  logic                video_clk,
    input  logic                reset,
    input  logic                framestart,
    input  logic                linestart,
    input  logic                prefetch_line,
    input  logic                pixelena,
    input  logic                hsync,
    input  logic                vsync,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_sof,
    output logic                line_req,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_de,
    output logic                out_hsync,
    output logic                out_vsync,
    output logic [FIFO_AW:0]    level,
    output logic [15:0]         underrun_cnt
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int RC_W  = $clog2(V_ACTIVE + 1);

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rd_data_q;
    logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]    level_q, level_d;
    logic                pop_q;
    logic [RC_W-1:0]     req_cnt_q;
    logic                prefetch_q, line_req_q;
    logic                out_de_q, out_hsync_q, out_vsync_q;
    logic [15:0]         underrun_q;

    logic full, empty, running, pop, underrun, accept, push, line_trig, req_open;

    assign full      = (level_q == (FIFO_AW + 1)'(DEPTH));
    assign empty     = (level_q == '0);
    assign running   = (state_q == RUN) && !framestart;
    assign pop       = running && pixelena && !empty;
    assign underrun  = running && pixelena && empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes a beat then.
    assign s_ready   = !reset && !framestart &&
                       ((state_q == SYNC) || ((state_q == RUN) && (!full || pop)));
    assign accept    = s_valid && s_ready;
    assign push      = accept && ((state_q == RUN) || s_sof);
    assign line_trig = (prefetch_line && !prefetch_q) || linestart;
    assign req_open  = (req_cnt_q < RC_W'(V_ACTIVE));

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge video_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            pop_q       <= 1'b0;
            req_cnt_q   <= '0;
            prefetch_q  <= 1'b0;
            line_req_q  <= 1'b0;
            out_de_q    <= 1'b0;
            out_hsync_q <= 1'b0;
            out_vsync_q <= 1'b0;
            underrun_q  <= '0;
        end else begin
            prefetch_q  <= prefetch_line;
            out_de_q    <= pixelena;
            out_hsync_q <= hsync;
            out_vsync_q <= vsync;
            pop_q       <= pop;
            if (framestart) begin
                state_q    <= SYNC;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                level_q    <= '0;
                req_cnt_q  <= '0;
                line_req_q <= 1'b0;
            end else begin
                if (state_q == SYNC && accept && s_sof)
                    state_q <= RUN;
                if (push)
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                level_q    <= level_d;
                line_req_q <= line_trig && req_open;
                if (line_trig && req_open)
                    req_cnt_q <= req_cnt_q + 1'b1;
            end
            if (underrun && underrun_q != 16'hFFFF)
                underrun_q <= underrun_q + 1'b1;
        end
    end

    // Storage: no reset, registered read; pop_q qualifies the read data.
    always_ff @(posedge video_clk) begin
        if (push)
            mem[wr_ptr_q] <= s_data;
        rd_data_q <= mem[rd_ptr_q];
    end

    assign out_data     = pop_q ? rd_data_q : BG_COLOR;
    assign out_de       = out_de_q;
    assign out_hsync    = out_hsync_q;
    assign out_vsync    = out_vsync_q;
    assign line_req     = line_req_q;
    assign level        = level_q;
    assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_video_pixout.sv
// Directed bench for video_pixout: one task per scenario, hand-computed expectations.
module tb_video_pixout;

    localparam logic [23:0] BG = 24'h000000;

    logic        video_clk;
    logic        reset;
    logic        framestart, linestart, prefetch_line, pixelena, hsync, vsync;
    logic        s_valid, s_sof;
    logic        s_ready;
    logic [23:0] s_data;
    logic        line_req;
    logic [23:0] out_data;
    logic        out_de, out_hsync, out_vsync;
    logic [11:0] level;
    logic [15:0] underrun_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [2:0] pat [12] = '{3'b000, 3'b100, 3'b110, 3'b101, 3'b000, 3'b111,
                             3'b010, 3'b001, 3'b100, 3'b000, 3'b110, 3'b011};

    video_pixout dut (
        .video_clk     (video_clk),
        .reset         (reset),
        .framestart    (framestart),
        .linestart     (linestart),
        .prefetch_line (prefetch_line),
        .pixelena      (pixelena),
        .hsync         (hsync),
        .vsync         (vsync),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_sof         (s_sof),
        .line_req      (line_req),
        .out_data      (out_data),
        .out_de        (out_de),
        .out_hsync     (out_hsync),
        .out_vsync     (out_vsync),
        .level         (level),
        .underrun_cnt  (underrun_cnt)
    );

    initial video_clk = 1'b0;
    always #5 video_clk = ~video_clk;

    task automatic cyc();
        @(posedge video_clk);
        #1;
    endtask

    task automatic frame_pulse();
        framestart = 1'b1;
        cyc();
        framestart = 1'b0;
    endtask

    task automatic push_n(input int n, input int base);
        s_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            s_data = 24'(base + i);
            s_sof  = (i == 0);
            cyc();
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        n_cmp++; if (level !== 12'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
        n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
        n_cmp++; if ({out_de, out_hsync, out_vsync, line_req} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl got=%b exp=0000", {out_de, out_hsync, out_vsync, line_req}); end
        n_cmp++; if (out_data !== BG) begin n_fail++; $display("FAIL reset_out_data got=%h exp=%h", out_data, BG); end
        n_cmp++; if (underrun_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_underrun got=%0d exp=0", underrun_cnt); end
        reset = 1'b0;
        #1;
        n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL idle_s_ready got=%b exp=0", s_ready); end
        $display("test_reset done");
    endtask

    task automatic test_sof_sync();
        framestart = 1'b1;
        #1;
        n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL fs_s_ready got=%b exp=0", s_ready); end
        cyc();
        framestart = 1'b0;
        s_valid = 1'b1; s_data = 24'd5; s_sof = 1'b0;
        #1;
        n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL sync_s_ready got=%b exp=1", s_ready); end
        cyc();
        s_data = 24'd6; s_sof = 1'b1;
        cyc();
        s_data = 24'd7; s_sof = 1'b0;
        cyc();
        s_valid = 1'b0;
        n_cmp++; if (level !== 12'd2) begin n_fail++; $display("FAIL sof_level got=%0d exp=2", level); end
        pixelena = 1'b1;
        cyc();
        n_cmp++; if (out_data !== 24'd6 || out_de !== 1'b1) begin
            n_fail++; $display("FAIL sof_pix0 got=%h de=%b exp=000006 de=1", out_data, out_de); end
        cyc();
        n_cmp++; if (out_data !== 24'd7) begin n_fail++; $display("FAIL sof_pix1 got=%h exp=000007", out_data); end
        cyc();
        n_cmp++; if (out_data !== BG || out_de !== 1'b1) begin
            n_fail++; $display("FAIL sof_pix2 got=%h de=%b exp=%h de=1", out_data, out_de, BG); end
        n_cmp++; if (underrun_cnt !== 16'd1) begin n_fail++; $display("FAIL sof_underrun got=%0d exp=1", underrun_cnt); end
        pixelena = 1'b0;
        cyc();
        n_cmp++; if (out_de !== 1'b0) begin n_fail++; $display("FAIL sof_de_off got=%b exp=0", out_de); end
        $display("test_sof_sync done");
    endtask

    task automatic test_full();
        int bad;
        int first_bad;
        logic [23:0] exp;
        bad = 0;
        first_bad = -1;
        frame_pulse();
        n_cmp++; if (underrun_cnt !== 16'd1) begin n_fail++; $display("FAIL fs_keeps_underrun got=%0d exp=1", underrun_cnt); end
        push_n(2048, 0);
        #1;
        n_cmp++; if (level !== 12'd2048) begin n_fail++; $display("FAIL full_level got=%0d exp=2048", level); end
        n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL full_s_ready got=%b exp=0", s_ready); end
        pixelena = 1'b1; s_valid = 1'b1; s_data = 24'hABCDEF;
        #1;
        n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL full_poppush_ready got=%b exp=1", s_ready); end
        cyc();
        s_valid = 1'b0;
        n_cmp++; if (level !== 12'd2048) begin n_fail++; $display("FAIL full_poppush_level got=%0d exp=2048", level); end
        n_cmp++; if (out_data !== 24'd0) begin n_fail++; $display("FAIL full_head got=%h exp=000000", out_data); end
        for (int k = 0; k < 2048; k++) begin
            cyc();
            exp = (k < 2047) ? 24'(k + 1) : 24'hABCDEF;
            if (out_data !== exp) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
        end
        pixelena = 1'b0;
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL drain_seq bad=%0d first_at=%0d exp bad=0", bad, first_bad); end
        n_cmp++; if (level !== 12'd0) begin n_fail++; $display("FAIL drain_level got=%0d exp=0", level); end
        n_cmp++; if (underrun_cnt !== 16'd1) begin n_fail++; $display("FAIL drain_underrun got=%0d exp=1", underrun_cnt); end
        $display("test_full done");
    endtask

    task automatic test_line_req();
        int cnt;
        cnt = 0;
        frame_pulse();
        prefetch_line = 1'b1; linestart = 1'b1;
        cyc();
        if (line_req) cnt++;
        linestart = 1'b0;
        cyc();
        if (line_req) cnt++;
        cyc();
        if (line_req) cnt++;
        n_cmp++; if (cnt !== 1) begin n_fail++; $display("FAIL coincident_req got=%0d exp=1", cnt); end
        for (int i = 1; i < 905; i++) begin
            linestart = 1'b1;
            cyc();
            if (line_req) cnt++;
            linestart = 1'b0;
            cyc();
            if (line_req) cnt++;
            if (i == 9) begin
                n_cmp++; if (cnt !== 10) begin n_fail++; $display("FAIL req_count_10 got=%0d exp=10", cnt); end
            end
        end
        cyc();
        if (line_req) cnt++;
        n_cmp++; if (cnt !== 900) begin n_fail++; $display("FAIL req_count_frame got=%0d exp=900", cnt); end
        prefetch_line = 1'b0;
        cnt = 0;
        frame_pulse();
        prefetch_line = 1'b1;
        cyc();
        if (line_req) cnt++;
        cyc();
        if (line_req) cnt++;
        cyc();
        if (line_req) cnt++;
        prefetch_line = 1'b0;
        n_cmp++; if (cnt !== 1) begin n_fail++; $display("FAIL req_new_frame got=%0d exp=1", cnt); end
        $display("test_line_req done");
    endtask

    task automatic test_align();
        int n;
        logic [23:0] exp;
        n = 0;
        frame_pulse();
        push_n(8, 24'h10);
        for (int i = 0; i < 12; i++) begin
            {pixelena, hsync, vsync} = pat[i];
            cyc();
            n_cmp++; if ({out_de, out_hsync, out_vsync} !== pat[i]) begin
                n_fail++; $display("FAIL align_ctrl[%0d] got=%b exp=%b", i, {out_de, out_hsync, out_vsync}, pat[i]); end
            if (pat[i][2]) begin
                exp = 24'(24'h10 + n);
                n++;
            end else begin
                exp = BG;
            end
            n_cmp++; if (out_data !== exp) begin n_fail++; $display("FAIL align_data[%0d] got=%h exp=%h", i, out_data, exp); end
        end
        {pixelena, hsync, vsync} = 3'b000;
        cyc();
        n_cmp++; if (out_de !== 1'b0 || out_data !== BG) begin
            n_fail++; $display("FAIL align_tail got de=%b data=%h exp de=0 data=%h", out_de, out_data, BG); end
        $display("test_align done");
    endtask

    task automatic test_flush();
        frame_pulse();
        push_n(300, 24'h100);
        n_cmp++; if (level !== 12'd300) begin n_fail++; $display("FAIL flush_pre_level got=%0d exp=300", level); end
        framestart = 1'b1; s_valid = 1'b1; s_data = 24'h123456; s_sof = 1'b1;
        #1;
        n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL flush_s_ready got=%b exp=0", s_ready); end
        cyc();
        framestart = 1'b0; s_valid = 1'b0; s_sof = 1'b0;
        n_cmp++; if (level !== 12'd0) begin n_fail++; $display("FAIL flush_level got=%0d exp=0", level); end
        #1;
        n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL flush_sync_ready got=%b exp=1", s_ready); end
        s_valid = 1'b1; s_data = 24'h000042;
        cyc();
        s_valid = 1'b0;
        n_cmp++; if (level !== 12'd0) begin n_fail++; $display("FAIL flush_sync_discard got=%0d exp=0", level); end
        $display("test_flush done");
    endtask

    task automatic test_reset_mid();
        frame_pulse();
        push_n(100, 24'h200);
        n_cmp++; if (level !== 12'd100) begin n_fail++; $display("FAIL rmid_pre_level got=%0d exp=100", level); end
        reset = 1'b1; pixelena = 1'b1; hsync = 1'b1;
        cyc();
        n_cmp++; if (level !== 12'd0) begin n_fail++; $display("FAIL rmid_level got=%0d exp=0", level); end
        n_cmp++; if (out_de !== 1'b0 || out_hsync !== 1'b0) begin
            n_fail++; $display("FAIL rmid_ctrl got de=%b hs=%b exp 0 0", out_de, out_hsync); end
        n_cmp++; if (underrun_cnt !== 16'd0) begin n_fail++; $display("FAIL rmid_underrun got=%0d exp=0", underrun_cnt); end
        n_cmp++; if (out_data !== BG) begin n_fail++; $display("FAIL rmid_data got=%h exp=%h", out_data, BG); end
        reset = 1'b0; pixelena = 1'b0; hsync = 1'b0;
        #1;
        n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_idle_ready got=%b exp=0", s_ready); end
        s_valid = 1'b1; s_sof = 1'b1; s_data = 24'h777777;
        cyc();
        s_valid = 1'b0; s_sof = 1'b0; pixelena = 1'b1;
        cyc();
        pixelena = 1'b0;
        n_cmp++; if (level !== 12'd0 || out_data !== BG || underrun_cnt !== 16'd0) begin
            n_fail++; $display("FAIL rmid_idle_out got lvl=%0d data=%h ur=%0d exp 0 %h 0", level, out_data, underrun_cnt, BG); end
        $display("test_reset_mid done");
    endtask

    initial begin
        reset = 1'b1;
        framestart = 1'b0; linestart = 1'b0; prefetch_line = 1'b0;
        pixelena = 1'b0; hsync = 1'b0; vsync = 1'b0;
        s_valid = 1'b0; s_sof = 1'b0; s_data = '0;
        test_reset();
        test_sof_sync();
        test_full();
        test_line_req();
        test_align();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
